arp_decode: RTL and testbench
=============================

Name: arp_decode

Overview:
- Sits directly downstream of the MAC receive decoder and consumes its ARP payload byte stream: one byte per cycle while arp_decode_valid is high, FCS already stripped.
- Parses the 28-byte Ethernet/IPv4 ARP body and validates the fixed header fields.
- For request/reply packets whose target IP equals IP_ADDR, presents sender MAC, sender IP and opcode on a valid/ready interface to the ARP responder/cache.

Parameters:
IP_ADDR, 32'hC0A80164, local IPv4 address (192.168.1.100) compared against TPA.
MAC_ADDR, 48'h000000000000, local MAC; reserved for the responder, not compared here.

Ports:
clk  input  1  clock.
rst  input  1  reset.
rxd  input  8  payload byte from MAC decoder.
arp_decode_valid  input  1  high while rxd carries ARP payload bytes.
busy  input  1  MAC decoder frame-active flag.
crc_err  input  1  MAC decoder FCS error flag.
arp_valid  output  1  result available.
arp_ready  input  1  consumer accepts result.
arp_oper  output  1  0 = request (OPER 1), 1 = reply (OPER 2).
sender_mac  output  48  SHA field, MSB = first byte received.
sender_ip  output  32  SPA field, MSB = first byte received.
overflow  output  1  one-cycle pulse: a valid packet was dropped because arp_valid was still pending.

Behaviour:
- Reset: rst is synchronous, active-high, clock clk. All outputs reset to 0; state = WAIT_LOW.
- Frame start: a rising edge of arp_decode_valid, meaning high now and low on the previous cycle. The first byte of the body is present on that same cycle.
- Byte counter: 5 bits, 0..27, saturates at 28.
- Field map:
  - 0-1 HTYPE = 0x0001
  - 2-3 PTYPE = 0x0800
  - 4 HLEN = 6
  - 5 PLEN = 4
  - 6-7 OPER = 1 or 2
  - 8-13 SHA
  - 14-17 SPA
  - 18-23 THA (ignored)
  - 24-27 TPA = IP_ADDR
- States:
  - WAIT_LOW: wait until arp_decode_valid is low, then go to IDLE. Covers reset mid-frame.
  - IDLE: on frame start, go to PARSE with counter = 1 and byte 0 checked.
  - PARSE: check each byte on arrival. On any fixed-field or TPA mismatch, go to DROP. SHA and SPA shift into internal holding registers; outputs are not touched until commit.
  - DROP: ignore bytes until arp_decode_valid is low, then go to IDLE.
  - PARSE after byte 27 passes: go to COMMIT without the gate, CRC_WAIT with the gate.
  - COMMIT: if arp_valid is 0 or (arp_valid and arp_ready) this cycle, load the outputs and set arp_valid = 1. Otherwise pulse overflow and discard the result. Then go to WAIT_LOW.
- Padding bytes (28..45) are ignored.
- Truncation: if arp_decode_valid falls in PARSE before byte 27, discard and go to IDLE; no output, no overflow.
- Latency: arp_valid rises 2 cycles after byte 27 is sampled (ungated).
- Handshake:
  - arp_valid stays high and outputs stay stable until sampled with arp_ready = 1.
  - arp_valid clears the cycle after the handshake unless COMMIT reloads it in that same cycle.
  - The arp_ready = 1 and COMMIT same-cycle case is a reload, not an overflow.
- Upper 3 bits of OPER high byte must be 0. OPER values 0 and 3+ are rejected.

Optional Feature:
- Macro ARP_CRC_GATE_EN.
- When defined, CRC_WAIT holds the candidate result until busy is low, then samples crc_err on the following cycle:
  - crc_err = 0: go to COMMIT.
  - crc_err = 1: discard and go to IDLE.
- CRC_WAIT timeout: 64 cycles; on expiry, discard and go to IDLE.
- When undefined, CRC_WAIT does not exist, busy and crc_err are ignored, and commit is immediate.

Test Plan:
- Valid request (0001 0800 06 04 0001, SHA 02:11:22:33:44:55, SPA C0A80102, TPA C0A80164) with arp_ready held high -> arp_valid pulses 1 cycle, 2 cycles after byte 27; arp_oper = 0; sender_mac = 0x021122334455; sender_ip = 0xC0A80102.
- Reply (OPER 0002) with arp_ready low for 10 cycles -> arp_valid stays high 10 cycles with stable outputs, arp_oper = 1; clears the cycle after arp_ready = 1.
- TPA = C0A80165, or PTYPE = 0x86DD, or OPER = 0003 -> no arp_valid; next valid packet is still decoded.
- arp_decode_valid drops after 20 bytes -> no output; immediately following valid packet decodes correctly.
- Two valid packets with arp_ready low -> first result held unchanged, overflow pulses once at second packet's commit.
- rst asserted at byte 10 and released while arp_decode_valid is still high -> all outputs 0, that frame ignored, next frame decoded. With ARP_CRC_GATE_EN defined, crc_err = 1 after busy falls -> no arp_valid.

Source files
------------

// File: rtl/arp_decode.sv
// arp_decode: parses the 28-byte Ethernet/IPv4 ARP body from the MAC receive path and
// hands matching requests/replies to the responder. Optional build macro: ARP_CRC_GATE_EN.
module arp_decode #(
    parameter logic [31:0] IP_ADDR  = 32'hC0A80164,
    parameter logic [47:0] MAC_ADDR = 48'h000000000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rxd,
    input  logic        arp_decode_valid,
    input  logic        busy,
    input  logic        crc_err,
    output logic        arp_valid,
    input  logic        arp_ready,
    output logic        arp_oper,
    output logic [47:0] sender_mac,
    output logic [31:0] sender_ip,
    output logic        overflow
);

    typedef enum logic [2:0] {
        WAIT_LOW,
        IDLE,
        PARSE,
        DROP,
        COMMIT
`ifdef ARP_CRC_GATE_EN
        , CRC_WAIT
`endif
    } state_t;

    state_t      state, state_nxt;
    logic        valid_d;
    logic        frame_start;
    logic [4:0]  cnt;
    logic [4:0]  idx;
    logic        byte_ok;
    logic        capture;
    logic [47:0] sha_h;
    logic [31:0] spa_h;
    logic        oper_h;
    logic        unused_ok;

    assign frame_start = arp_decode_valid && !valid_d;
    // In IDLE the counter may hold a stale value from a truncated frame; byte 0 is implied.
    assign idx         = (state == IDLE) ? 5'd0 : cnt;
    assign capture     = (state == IDLE && frame_start) || (state == PARSE);
    // MAC_ADDR belongs to the responder; busy/crc_err only matter with the CRC gate.
    assign unused_ok   = &{1'b0, busy, crc_err, MAC_ADDR};

    always_comb begin
        byte_ok = 1'b1;
        case (idx)
            5'd0:    byte_ok = (rxd == 8'h00);
            5'd1:    byte_ok = (rxd == 8'h01);
            5'd2:    byte_ok = (rxd == 8'h08);
            5'd3:    byte_ok = (rxd == 8'h00);
            5'd4:    byte_ok = (rxd == 8'h06);
            5'd5:    byte_ok = (rxd == 8'h04);
            5'd6:    byte_ok = (rxd == 8'h00);
            5'd7:    byte_ok = (rxd == 8'h01) || (rxd == 8'h02);
            5'd24:   byte_ok = (rxd == IP_ADDR[31:24]);
            5'd25:   byte_ok = (rxd == IP_ADDR[23:16]);
            5'd26:   byte_ok = (rxd == IP_ADDR[15:8]);
            5'd27:   byte_ok = (rxd == IP_ADDR[7:0]);
            default: byte_ok = 1'b1;
        endcase
    end

`ifdef ARP_CRC_GATE_EN
    logic [5:0] crc_tmo;
    logic       busy_low;

    always_ff @(posedge clk) begin
        if (rst || state != CRC_WAIT) begin
            crc_tmo  <= 6'd0;
            busy_low <= 1'b0;
        end else begin
            crc_tmo <= crc_tmo + 6'd1;
            if (!busy) busy_low <= 1'b1;
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_LOW: if (!arp_decode_valid) state_nxt = IDLE;
            IDLE:     if (frame_start) state_nxt = byte_ok ? PARSE : DROP;
            PARSE: begin
                if (!arp_decode_valid)  state_nxt = IDLE;
                else if (!byte_ok)      state_nxt = DROP;
                else if (cnt == 5'd27)
`ifdef ARP_CRC_GATE_EN
                                        state_nxt = CRC_WAIT;
`else
                                        state_nxt = COMMIT;
`endif
            end
            DROP:     if (!arp_decode_valid) state_nxt = IDLE;
            COMMIT:   state_nxt = WAIT_LOW;
`ifdef ARP_CRC_GATE_EN
            // crc_err is looked at one cycle after busy is first seen low.
            CRC_WAIT: begin
                if (busy_low)               state_nxt = crc_err ? IDLE : COMMIT;
                else if (crc_tmo == 6'd63)  state_nxt = IDLE;
            end
`endif
            default:  state_nxt = WAIT_LOW;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= WAIT_LOW;
            valid_d <= 1'b0;
        end else begin
            state   <= state_nxt;
            valid_d <= arp_decode_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= 5'd0;
            sha_h  <= 48'd0;
            spa_h  <= 32'd0;
            oper_h <= 1'b0;
        end else begin
            if (state == PARSE)
                cnt <= (cnt == 5'd28) ? cnt : cnt + 5'd1;
            else if (state == IDLE && frame_start)
                cnt <= 5'd1;
            else
                cnt <= 5'd0;

            if (capture) begin
                if (idx == 5'd7)                   oper_h <= rxd[1];
                if (idx >= 5'd8  && idx <= 5'd13)  sha_h  <= {sha_h[39:0], rxd};
                if (idx >= 5'd14 && idx <= 5'd17)  spa_h  <= {spa_h[23:0], rxd};
            end
        end
    end

    // A commit landing on the handshake cycle reloads instead of overflowing.
    always_ff @(posedge clk) begin
        if (rst) begin
            arp_valid  <= 1'b0;
            arp_oper   <= 1'b0;
            sender_mac <= 48'd0;
            sender_ip  <= 32'd0;
            overflow   <= 1'b0;
        end else begin
            overflow <= 1'b0;
            if (arp_valid && arp_ready) arp_valid <= 1'b0;
            if (state == COMMIT) begin
                if (!arp_valid || arp_ready) begin
                    arp_valid  <= 1'b1;
                    arp_oper   <= oper_h;
                    sender_mac <= sha_h;
                    sender_ip  <= spa_h;
                end else begin
                    overflow <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_arp_decode.sv
// Self-checking bench for arp_decode: directed scenarios plus randomized packets
// compared against a field-level ARP acceptance model.
`timescale 1ns/1ps
module tb_arp_decode;

    localparam logic [31:0] MY_IP = 32'hC0A80164;
`ifdef ARP_CRC_GATE_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rxd = 8'd0;
    logic        adv = 1'b0;
    logic        busy = 1'b0;
    logic        crc_err = 1'b0;
    logic        arp_ready = 1'b0;
    logic        arp_valid, arp_oper, overflow;
    logic [47:0] sender_mac;
    logic [31:0] sender_ip;

    int checks = 0;
    int failures = 0;
    int rise_cnt = 0;
    int ovf_cnt = 0;
    logic        prev_v = 1'b0;
    logic [47:0] cap_mac = '0;
    logic [31:0] cap_ip = '0;
    logic        cap_oper = 1'b0;

    arp_decode #(.IP_ADDR(MY_IP), .MAC_ADDR(48'h0)) dut (
        .clk(clk), .rst(rst), .rxd(rxd), .arp_decode_valid(adv), .busy(busy),
        .crc_err(crc_err), .arp_valid(arp_valid), .arp_ready(arp_ready),
        .arp_oper(arp_oper), .sender_mac(sender_mac), .sender_ip(sender_ip),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (arp_valid && !prev_v) begin
            rise_cnt <= rise_cnt + 1;
            cap_mac  <= sender_mac;
            cap_ip   <= sender_ip;
            cap_oper <= arp_oper;
        end
        if (overflow) ovf_cnt <= ovf_cnt + 1;
        prev_v <= arp_valid;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Packet as a 224-bit vector, first byte in the MSBs.
    function automatic logic [223:0] mk_pkt(input logic [15:0] oper, input logic [47:0] sha,
                                            input logic [31:0] spa, input logic [31:0] tpa);
        logic [47:0] tha;
        tha = {16'($urandom), 32'($urandom)};
        return {16'h0001, 16'h0800, 8'd6, 8'd4, oper, sha, spa, tha, tpa};
    endfunction

    function automatic bit model_accept(input logic [223:0] p, input int len);
        if (len < 28) return 1'b0;
        return p[223:208] == 16'h0001 && p[207:192] == 16'h0800 && p[191:184] == 8'd6 &&
               p[183:176] == 8'd4 && (p[175:160] == 16'd1 || p[175:160] == 16'd2) &&
               p[31:0] == MY_IP;
    endfunction

    function automatic logic [47:0] rnd48();
        return {16'($urandom), 32'($urandom)};
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One idle cycle, len body bytes, pad padding bytes; returns in the cycle after the last byte.
    task automatic drive(input logic [223:0] p, input int len, input int pad);
        adv = 1'b0; rxd = 8'd0;
        step(1);
        for (int i = 0; i < len; i++) begin
            adv = 1'b1;
            rxd = p[223-8*i -: 8];
            step(1);
        end
        for (int i = 0; i < pad; i++) begin
            rxd = 8'($urandom);
            step(1);
        end
        adv = 1'b0; rxd = 8'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(3);
        checks++;
        if (arp_valid !== 1'b0 || overflow !== 1'b0 || arp_oper !== 1'b0 ||
            sender_mac !== 48'd0 || sender_ip !== 32'd0) begin
            failures++;
            $display("FAIL reset_outputs: got v=%b ovf=%b op=%b mac=%h ip=%h, want all 0",
                     arp_valid, overflow, arp_oper, sender_mac, sender_ip);
        end
        rst = 1'b0;
        step(2);
    endtask

    task automatic test_request();
        logic [223:0] p;
        arp_ready = 1'b1;
        p = mk_pkt(16'd1, 48'h021122334455, 32'hC0A80102, MY_IP);
        drive(p, 28, 0);
        checks++;
        if (arp_valid !== 1'b0) begin
            failures++;
            $display("FAIL req_early: arp_valid=%b want 0 one cycle after byte 27", arp_valid);
        end
        step(LAT - 1);
        checks++;
        if (arp_valid !== 1'b1 || arp_oper !== 1'b0 || sender_mac !== 48'h021122334455 ||
            sender_ip !== 32'hC0A80102) begin
            failures++;
            $display("FAIL req_result: got v=%b op=%b mac=%h ip=%h want 1 0 021122334455 c0a80102",
                     arp_valid, arp_oper, sender_mac, sender_ip);
        end
        step(1);
        checks++;
        if (arp_valid !== 1'b0) begin
            failures++;
            $display("FAIL req_pulse: arp_valid=%b want 0 after handshake", arp_valid);
        end
        step(4);
    endtask

    task automatic test_hold_reply();
        logic [223:0] p;
        logic [47:0]  mac;
        logic [31:0]  ip;
        mac = rnd48();
        ip  = $urandom;
        arp_ready = 1'b0;
        p = mk_pkt(16'd2, mac, ip, MY_IP);
        drive(p, 28, 0);
        step(LAT - 1);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (arp_valid !== 1'b1 || arp_oper !== 1'b1 || sender_mac !== mac || sender_ip !== ip) begin
                failures++;
                $display("FAIL hold_cycle%0d: got v=%b op=%b mac=%h ip=%h want 1 1 %h %h",
                         i, arp_valid, arp_oper, sender_mac, sender_ip, mac, ip);
            end
            step(1);
        end
        arp_ready = 1'b1;
        step(1);
        checks++;
        if (arp_valid !== 1'b0) begin
            failures++;
            $display("FAIL hold_clear: arp_valid=%b want 0 after ready", arp_valid);
        end
        step(3);
    endtask

    task automatic test_rejects();
        logic [223:0] p;
        logic [223:0] good;
        int r0;
        arp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (k == 0) p = mk_pkt(16'd1, rnd48(), $urandom, 32'hC0A80165);
            else if (k == 1) begin
                p = mk_pkt(16'd1, rnd48(), $urandom, MY_IP);
                p[207:192] = 16'h86DD;
            end else p = mk_pkt(16'd3, rnd48(), $urandom, MY_IP);
            r0 = rise_cnt;
            drive(p, 28, $urandom_range(0, 18));
            step(8);
            checks++;
            if (rise_cnt !== r0) begin
                failures++;
                $display("FAIL reject%0d: results=%0d want 0", k, rise_cnt - r0);
            end
        end
        good = mk_pkt(16'd2, rnd48(), $urandom, MY_IP);
        r0 = rise_cnt;
        drive(good, 28, 5);
        step(8);
        checks++;
        if (rise_cnt !== r0 + 1 || cap_mac !== good[159:112] || cap_ip !== good[111:80] ||
            cap_oper !== 1'b1) begin
            failures++;
            $display("FAIL reject_recover: n=%0d mac=%h ip=%h op=%b want 1 %h %h 1",
                     rise_cnt - r0, cap_mac, cap_ip, cap_oper, good[159:112], good[111:80]);
        end
    endtask

    task automatic test_truncation();
        logic [223:0] p;
        logic [223:0] good;
        int r0;
        arp_ready = 1'b1;
        p    = mk_pkt(16'd1, rnd48(), $urandom, MY_IP);
        good = mk_pkt(16'd1, rnd48(), $urandom, MY_IP);
        r0 = rise_cnt;
        drive(p, 20, 0);
        drive(good, 28, 0);
        step(8);
        checks++;
        if (rise_cnt !== r0 + 1 || cap_mac !== good[159:112] || cap_ip !== good[111:80] ||
            cap_oper !== 1'b0) begin
            failures++;
            $display("FAIL truncation: n=%0d mac=%h ip=%h want 1 %h %h",
                     rise_cnt - r0, cap_mac, cap_ip, good[159:112], good[111:80]);
        end
    endtask

    task automatic test_overflow_reload();
        logic [223:0] a, b, c;
        int o0;
        arp_ready = 1'b0;
        a = mk_pkt(16'd1, rnd48(), $urandom, MY_IP);
        b = mk_pkt(16'd2, rnd48(), $urandom, MY_IP);
        c = mk_pkt(16'd2, rnd48(), $urandom, MY_IP);
        o0 = ovf_cnt;
        drive(a, 28, 0);
        step(LAT);
        drive(b, 28, 3);
        step(8);
        checks++;
        if (arp_valid !== 1'b1 || sender_mac !== a[159:112] || sender_ip !== a[111:80] ||
            arp_oper !== 1'b0) begin
            failures++;
            $display("FAIL ovf_hold: v=%b mac=%h ip=%h want 1 %h %h",
                     arp_valid, sender_mac, sender_ip, a[159:112], a[111:80]);
        end
        checks++;
        if (ovf_cnt !== o0 + 1) begin
            failures++;
            $display("FAIL ovf_pulse: pulses=%0d want 1", ovf_cnt - o0);
        end
        // ready rises exactly in the commit cycle of c: reload, no overflow
        drive(c, 28, 0);
        step(LAT - 2);
        arp_ready = 1'b1;
        step(1);
        arp_ready = 1'b0;
        checks++;
        if (arp_valid !== 1'b1 || sender_mac !== c[159:112] || sender_ip !== c[111:80] ||
            arp_oper !== 1'b1 || ovf_cnt !== o0 + 1) begin
            failures++;
            $display("FAIL reload: v=%b mac=%h ip=%h pulses=%0d want 1 %h %h 1",
                     arp_valid, sender_mac, sender_ip, ovf_cnt - o0, c[159:112], c[111:80]);
        end
        arp_ready = 1'b1;
        step(1);
        checks++;
        if (arp_valid !== 1'b0) begin
            failures++;
            $display("FAIL reload_clear: arp_valid=%b want 0", arp_valid);
        end
        step(3);
    endtask

    task automatic test_reset_midframe();
        logic [223:0] p, good;
        int r0;
        arp_ready = 1'b0;
        drive(mk_pkt(16'd1, rnd48(), $urandom, MY_IP), 28, 0);
        step(LAT + 2);
        p = mk_pkt(16'd1, rnd48(), $urandom, MY_IP);
        adv = 1'b0;
        step(1);
        for (int i = 0; i < 28; i++) begin
            adv = 1'b1;
            rxd = p[223-8*i -: 8];
            rst = (i == 10);
            step(1);
            if (i == 10) begin
                checks++;
                if (arp_valid !== 1'b0 || overflow !== 1'b0 || arp_oper !== 1'b0 ||
                    sender_mac !== 48'd0 || sender_ip !== 32'd0) begin
                    failures++;
                    $display("FAIL midframe_reset: v=%b ovf=%b op=%b mac=%h ip=%h want all 0",
                             arp_valid, overflow, arp_oper, sender_mac, sender_ip);
                end
            end
        end
        rst = 1'b0;
        adv = 1'b0;
        rxd = 8'd0;
        r0 = rise_cnt;
        step(8);
        checks++;
        if (rise_cnt !== r0 || arp_valid !== 1'b0) begin
            failures++;
            $display("FAIL midframe_ignored: results=%0d v=%b want 0 0", rise_cnt - r0, arp_valid);
        end
        arp_ready = 1'b1;
        good = mk_pkt(16'd2, rnd48(), $urandom, MY_IP);
        drive(good, 28, 2);
        step(8);
        checks++;
        if (rise_cnt !== r0 + 1 || cap_mac !== good[159:112] || cap_ip !== good[111:80]) begin
            failures++;
            $display("FAIL midframe_next: n=%0d mac=%h ip=%h want 1 %h %h",
                     rise_cnt - r0, cap_mac, cap_ip, good[159:112], good[111:80]);
        end
    endtask

    // busy/crc_err only steer the result when the gate is built in.
    task automatic test_crc_gate();
        logic [223:0] p;
        int r0;
        int exp_n;
        arp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            p = mk_pkt(16'd1, rnd48(), $urandom, MY_IP);
            busy = 1'b1;
            crc_err = (k == 0);
            r0 = rise_cnt;
            drive(p, 28, 4);
            if (k == 2) step(80);
            busy = 1'b0;
            step(10);
            crc_err = 1'b0;
`ifdef ARP_CRC_GATE_EN
            exp_n = (k == 1) ? 1 : 0;
`else
            exp_n = 1;
`endif
            checks++;
            if (rise_cnt !== r0 + exp_n) begin
                failures++;
                $display("FAIL crc_case%0d: results=%0d want %0d", k, rise_cnt - r0, exp_n);
            end
        end
    endtask

    task automatic test_random();
        logic [223:0] p;
        int r0, len, kind;
        bit exp;
        arp_ready = 1'b1;
        for (int n = 0; n < 40; n++) begin
            p = mk_pkt(16'($urandom_range(1, 2)), rnd48(), $urandom, MY_IP);
            len = 28;
            kind = $urandom_range(0, 7);
            case (kind)
                1: p[223 - 8*$urandom_range(0, 5) -: 8] = p[223 - 8*$urandom_range(0, 5) -: 8] ^ 8'($urandom_range(1, 255));
                2: p[175:160] = 16'($urandom_range(0, 7));
                3: p[31:0] = p[31:0] ^ (32'd1 << $urandom_range(0, 31));
                4: len = $urandom_range(1, 27);
                default: ;
            endcase
            exp = model_accept(p, len);
            r0 = rise_cnt;
            drive(p, len, (len == 28) ? $urandom_range(0, 18) : 0);
            step(8);
            checks++;
            if (rise_cnt !== r0 + int'(exp)) begin
                failures++;
                $display("FAIL rand%0d_accept: results=%0d want %0d (kind %0d)",
                         n, rise_cnt - r0, exp, kind);
            end else if (exp) begin
                checks++;
                if (cap_mac !== p[159:112] || cap_ip !== p[111:80] ||
                    cap_oper !== (p[175:160] == 16'd2)) begin
                    failures++;
                    $display("FAIL rand%0d_fields: mac=%h ip=%h op=%b want %h %h %b", n,
                             cap_mac, cap_ip, cap_oper, p[159:112], p[111:80], p[175:160] == 16'd2);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_request();
        test_hold_reply();
        test_rejects();
        test_truncation();
        test_overflow_reload();
        test_reset_midframe();
        test_crc_gate();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
